// File: rtl/led_pwm_stage.sv
// LED output stage: global PWM dimming plus optional blink, applied to the
// pattern coming from the LED register driver. One control register on the
// shared IO bus holds the duty value and the blink enable.
module led_pwm_stage #(
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned BLINK_PERIODS = 48828,
    parameter logic [11:0] CTRL_ADDR     = 12'h068
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [11:0] io_addr,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    input  logic [23:0] led_in,
    output logic [23:0] led_out
);

    // Blink counter needs at least one bit even when a half-phase is one period.
    localparam int unsigned BLINK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_PERIODS - 1);
    localparam logic [BLINK_W-1:0]  BLINK_ONE  = BLINK_W'(1);
    localparam logic [BLINK_W-1:0]  BLINK_ZERO = BLINK_W'(0);
    localparam logic [PWM_BITS-1:0] PWM_FULL   = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] PWM_ZERO   = PWM_BITS'(0);

    logic                r_duty_s;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_blink_en;
    logic [PWM_BITS-1:0] r_active_duty;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic                r_blink_phase;

    logic                w_addr_hit;
    logic                w_wr;
    logic                w_rd;
    logic                w_period_end;
    logic                w_pwm_on;
    logic                w_unused_wdata;

    assign w_addr_hit   = (io_addr == CTRL_ADDR);
    assign w_wr         = io_en & io_we & w_addr_hit;
    assign w_rd         = io_en & ~io_we & w_addr_hit;
    assign w_period_end = (r_pwm_cnt == PWM_FULL);
    // Full duty is forced on so the output has no dark cycle at the wrap.
    assign w_pwm_on     = (r_active_duty == PWM_FULL) | (r_pwm_cnt < r_active_duty);

    // Reserved write-data bits above blink_en are ignored; fold them so they are visibly consumed.
    assign w_unused_wdata = ^io_write_data[31:PWM_BITS+1];
    assign r_duty_s       = w_unused_wdata;

    // Control register readback, zero outside a read of our own address.
    always_comb begin
        io_read_data = 32'd0;
        if (w_rd) begin
            io_read_data = 32'({r_blink_en, r_duty});
        end else begin
            io_read_data = 32'd0;
        end
    end

    // Control register: duty and blink enable, written from the IO bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty     <= PWM_FULL;
            r_blink_en <= 1'b0;
        end else if (w_wr) begin
            r_duty     <= io_write_data[PWM_BITS-1:0];
            r_blink_en <= io_write_data[PWM_BITS];
        end
    end

    // Free-running PWM counter; one full wrap is one PWM period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= PWM_ZERO;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
        end
    end

    // Shadow duty, reloaded only at a period end so a new duty never truncates a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_duty <= PWM_FULL;
        end else if (w_period_end) begin
            r_active_duty <= r_duty;
        end
    end

    // Blink sequencer: counts PWM periods per half-phase, parked lit while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= BLINK_ZERO;
            r_blink_phase <= 1'b1;
        end else if (!r_blink_en) begin
            r_blink_cnt   <= BLINK_ZERO;
            r_blink_phase <= 1'b1;
        end else if (w_period_end) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= BLINK_ZERO;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + BLINK_ONE;
            end
        end
    end

    // Registered LED drive: pattern gated by PWM and blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out <= 24'd0;
        end else begin
            led_out <= led_in & {24{w_pwm_on & r_blink_phase}};
        end
    end

endmodule

// File: doc/led_pwm_stage.md
Name: led_pwm_stage

Overview:
- Output stage placed directly downstream of the LED register driver; consumes its 24-bit device_led word and drives the board LED pins.
- Adds global brightness (PWM dimming) and an optional blink mode, both programmed through one memory-mapped control register on the same IO bus (io_en/io_addr/io_write_data).
- Reset configuration is full brightness, no blink, so LED behaviour is unchanged until software writes the control register.

Parameters:
- PWM_BITS, 8, width of the PWM counter and the duty field.
- BLINK_PERIODS, 48828, number of complete PWM periods per blink half-phase; must be ≥1.
- CTRL_ADDR, 12'h068, IO address of the control register.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- io_en  input  1  IO access strobe, valid for one cycle per access.
- io_we  input  1  1 = write, 0 = read; qualified by io_en.
- io_addr  input  12  IO address.
- io_write_data  input  32  write data.
- io_read_data  output  32  control-register readback; combinational.
- led_in  input  24  LED pattern from the LED driver.
- led_out  output  24  registered drive to the LED pins.

Behaviour:
- Write strobe: wr = io_en & io_we & (io_addr == CTRL_ADDR).
- ctrl_reg layout:
  - [PWM_BITS-1:0] duty.
  - [PWM_BITS] blink_en.
  - Other bits read as 0 and writes to them are ignored.
- ctrl_reg updates on the clk edge where wr=1.
- io_read_data = {zero-extended ctrl_reg} when io_en & ~io_we & addr match; otherwise 0.
- Reset values: duty = all ones, blink_en = 0, active_duty = all ones, pwm_cnt = 0, blink_cnt = 0, blink_phase = 1, led_out = 0.
- pwm_cnt: PWM_BITS-wide free-running up-counter; wraps from all-ones to 0.
- period_end = (pwm_cnt == all ones).
- active_duty: shadow of ctrl_reg.duty, loaded only on the edge where period_end = 1, so a new duty takes effect at the start of the next PWM period (glitch-free).
- If wr and period_end occur in the same cycle, active_duty loads the old ctrl_reg value; the new value is applied at the following period end.
- pwm_on = (active_duty == all ones) | (pwm_cnt < active_duty).
  - duty 0: always off.
  - duty all-ones: always on.
  - Otherwise on for exactly active_duty cycles of every 2^PWM_BITS.
- Blink, when blink_en = 1:
  - blink_cnt increments on each period_end.
  - When blink_cnt == BLINK_PERIODS-1 at period_end: blink_cnt ← 0 and blink_phase toggles.
- Blink, when blink_en = 0: blink_cnt held at 0 and blink_phase held at 1, evaluated every cycle.
- Enabling blink therefore always starts in the lit phase, with a full half-phase.
- Output: led_out <= led_in & {24{pwm_on & blink_phase}}, registered.
  - Latency: 1 cycle from led_in or PWM/blink state to led_out.
  - No combinational path from led_in to led_out.
- Asserting rst_n low mid-period or mid-blink immediately forces all state to its reset values, including led_out = 0.
- After release, pwm_cnt restarts at 0.

Test Plan (bench uses PWM_BITS=4, BLINK_PERIODS=2):
- Reset, then led_in = 24'hA5A5A5 with no writes -> led_out = 24'hA5A5A5 on every cycle from the 2nd edge after release, and 0 during reset.
- Write duty = 4, led_in = 24'hFFFFFF -> after the next period end, led_out = FFFFFF for 4 cycles then 0 for 12 cycles, repeating every 16 cycles; read of CTRL_ADDR returns 32'h4 immediately after the write.
- Write duty = 0 -> led_out = 0 constantly from the next period. Write duty = 4'hF -> led_out = led_in constantly, with no 1-cycle off gap at the period boundary.
- Duty write on the cycle where pwm_cnt = 15 -> old duty is used for one more full period; new duty applies 16 cycles later.
- Write {blink_en=1, duty=F}, led_in = 24'h000001 -> led_out = 1 for 32 cycles, then 0 for 32 cycles, repeating. Clearing blink_en mid-dark-phase -> led_out = 1 one cycle after blink_phase is forced to 1.
- Write to CTRL_ADDR+4, or a read access (io_we=0) at CTRL_ADDR -> ctrl_reg unchanged. Pulse rst_n low mid-blink -> led_out = 0 immediately and ctrl_reg = {blink_en=0, duty=F} after release.
